// File: rtl/plot_framebuffer.sv
// Pixel-plot sink: 160x120x3 frame buffer with hardware clear and 640x480 VGA scan-out (4x4 replicated).
// Plot writes land on the next edge; scan-out lags the h/v counters by 2 cycles; plots are refused (oDrop) while clearing.
module plot_framebuffer #(
  parameter int X_PIXELS   = 160,
  parameter int Y_PIXELS   = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  input  logic       iClear,
  output logic       oReady,
  output logic       oDrop,
  output logic [2:0] oColour,
  output logic       oHS,
  output logic       oVS,
  output logic       oBlank_n,
  output logic       oFrameStart
);

  localparam int FB_WORDS = X_PIXELS * Y_PIXELS;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]  X_LIM    = 8'(X_PIXELS);
  localparam logic [6:0]  Y_LIM    = 7'(Y_PIXELS);
  localparam logic [14:0] CLR_LAST = 15'(FB_WORDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [14:0] clr_cnt_q;
  logic        clr_we;

  logic        plot_ok;
  logic        plot_we;
  logic [14:0] plot_addr;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_dat;

  logic [9:0]  h_q;
  logic [9:0]  v_q;
  logic [9:0]  h_px;
  logic [9:0]  v_px;
  logic        act_raw;
  logic        hs_raw;
  logic        vs_raw;
  logic        fs_raw;
  logic [14:0] scan_addr;

  logic [14:0] rd_addr_q;
  logic [2:0]  rd_dat;
  logic        blank1_q, hs1_q, vs1_q, fs1_q;
  logic        blank2_q, hs2_q, vs2_q, fs2_q;
  logic        drop_q;

  logic [2:0]  mem [0:FB_WORDS-1];

  // Clear sequencer
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (iClear) state_d = CLEAR;
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == CLR_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 15'd1;
    end else begin
      clr_cnt_q <= '0;
    end
  end

  assign oReady = (state_q == IDLE);

  // y*160 + x as (y<<7) + (y<<5) + x
  assign plot_addr = ({8'd0, iY} << 7) + ({8'd0, iY} << 5) + {7'd0, iX};
  assign plot_ok   = (state_q == IDLE) && !iClear && (iX < X_LIM) && (iY < Y_LIM);
  assign plot_we   = iPlot && plot_ok;

  assign wr_en   = clr_we || plot_we;
  assign wr_addr = clr_we ? clr_cnt_q : plot_addr;
  assign wr_dat  = clr_we ? 3'd0 : iColour;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= iPlot && !plot_ok;
    end
  end

  assign oDrop = drop_q;

  // Read-before-write: a same-cycle write to the scanned address shows the old pixel
  always_ff @(posedge iClock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_dat <= mem[rd_addr_q];
  end

  assign h_px      = h_q >> SCALE_LOG2;
  assign v_px      = v_q >> SCALE_LOG2;
  assign scan_addr = ({5'd0, v_px} << 7) + ({5'd0, v_px} << 5) + {5'd0, h_px};

  assign act_raw = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw  = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_raw  = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign fs_raw  = (h_q == 10'd0) && (v_q == 10'd0);

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      h_q       <= '0;
      v_q       <= '0;
      rd_addr_q <= '0;
      blank1_q  <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      fs1_q     <= 1'b0;
      blank2_q  <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      fs2_q     <= 1'b0;
    end else begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
      // Blanked positions read address 0 so the index always stays in range
      rd_addr_q <= act_raw ? scan_addr : 15'd0;
      blank1_q  <= act_raw;
      hs1_q     <= hs_raw;
      vs1_q     <= vs_raw;
      fs1_q     <= fs_raw;
      blank2_q  <= blank1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      fs2_q     <= fs1_q;
    end
  end

  assign oColour     = blank2_q ? rd_dat : 3'd0;
  assign oHS         = hs2_q;
  assign oVS         = vs2_q;
  assign oBlank_n    = blank2_q;
  assign oFrameStart = fs2_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: sync timing on the first lines, clear length, plot accept/drop, scan image and collision.
module tb_plot_framebuffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic       ready;
  logic       drop;
  logic [2:0] pix;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  plot_framebuffer dut (
    .iClock      (clk),
    .iResetn     (rst_n),
    .iX          (x),
    .iY          (y),
    .iColour     (colour),
    .iPlot       (plot),
    .iClear      (clear),
    .oReady      (ready),
    .oDrop       (drop),
    .oColour     (pix),
    .oHS         (hs),
    .oVS         (vs),
    .oBlank_n    (blank_n),
    .oFrameStart (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_plot(input int px, input int py, input int pc);
    plot   = 1'b1;
    x      = 8'(px);
    y      = 7'(py);
    colour = 3'(pc);
  endtask

  initial begin
    int blank_cnt [2];
    int hs_cnt [2];
    int fall_at [2];
    int n_fall;
    int fs_cnt;
    int fs_pos;
    int vs_low;
    int pos_err;
    int low;
    int drop_mid;
    int scan_err;
    int six;
    logic prev_hs;

    // Reset values
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_drop", drop, 0);
    chk("rst_colour", pix, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_blank", blank_n, 0);
    chk("rst_fs", frame_start, 0);
    tick();
    rst_n = 1'b1;

    // First two lines: output position p = sample index - 2
    blank_cnt = '{0, 0};
    hs_cnt    = '{0, 0};
    fall_at   = '{-1, -1};
    n_fall = 0; fs_cnt = 0; fs_pos = -1; vs_low = 0; pos_err = 0;
    prev_hs = 1'b1;
    for (int k = 1; k <= 1601; k++) begin
      int p;
      int h;
      tick();
      p = k - 2;
      if (p >= 0) begin
        h = p % 800;
        if (blank_n) blank_cnt[p / 800]++;
        if (!hs) hs_cnt[p / 800]++;
        if (prev_hs && !hs && n_fall < 2) begin
          fall_at[n_fall] = p;
          n_fall++;
        end
        if (blank_n !== (h < 640)) pos_err++;
        if (hs !== !(h >= 656 && h <= 751)) pos_err++;
      end
      if (frame_start) begin
        fs_cnt++;
        fs_pos = k;
      end
      if (!vs) vs_low++;
      prev_hs = hs;
    end
    chk("blank_line0", blank_cnt[0], 640);
    chk("blank_line1", blank_cnt[1], 640);
    chk("hs_low_line0", hs_cnt[0], 96);
    chk("hs_low_line1", hs_cnt[1], 96);
    chk("hs_first_fall", fall_at[0], 656);
    chk("hs_period", fall_at[1] - fall_at[0], 800);
    chk("fs_count", fs_cnt, 1);
    chk("fs_latency", fs_pos, 2);
    chk("vs_early_low", vs_low, 0);
    chk("timing_pos_err", pos_err, 0);

    // Full clear; a second iClear mid-way must not restart it
    clear = 1'b1;
    tick();
    clear = 1'b0;
    low = 0;
    drop_mid = -1;
    while (!ready && low < 25000) begin
      low++;
      if (low == 300) clear = 1'b1;
      if (low == 19000) drive_plot(1, 1, 5);
      tick();
      if (low == 300) clear = 1'b0;
      if (low == 19000) begin
        plot = 1'b0;
        drop_mid = int'(drop);
      end
    end
    chk("clear_len", low, 19200);
    chk("drop_mid_clear", drop_mid, 1);

    // Plots after the clear
    drive_plot(5, 3, 6);
    tick();
    chk("drop_valid", drop, 0);
    drive_plot(160, 0, 7);
    tick();
    chk("drop_x_range", drop, 1);
    drive_plot(0, 120, 7);
    tick();
    chk("drop_y_range", drop, 1);
    drive_plot(159, 119, 2);
    tick();
    chk("drop_corner", drop, 0);
    plot = 1'b0;
    tick();
    chk("drop_idle", drop, 0);

    // Restart scan (memory survives reset) and check lines 0..15
    do_reset();
    chk("ready_after_rst", ready, 1);
    scan_err = 0;
    six = 0;
    tick();
    for (int k = 2; k < 2 + 16 * 800; k++) begin
      int p;
      int h;
      int v;
      int e;
      tick();
      p = k - 2;
      h = p % 800;
      v = p / 800;
      e = (h < 640 && v >= 12 && v <= 15 && h >= 20 && h <= 23) ? 6 : 0;
      if (pix !== 3'(e)) scan_err++;
      if (pix == 3'd6) six++;
    end
    chk("scan_err", scan_err, 0);
    chk("scan_six", six, 16);

    // Clear and plot in one idle cycle, then reset part-way through the clear
    clear = 1'b1;
    drive_plot(2, 2, 4);
    tick();
    clear = 1'b0;
    plot = 1'b0;
    chk("clr_plot_ready", ready, 0);
    chk("clr_plot_drop", drop, 1);
    for (int i = 0; i < 4999; i++) tick();
    chk("mid_clear_busy", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    tick();
    rst_n = 1'b1;

    // Write address 0 in the cycle the scan reads it
    tick();
    drive_plot(0, 0, 3);
    tick();
    plot = 1'b0;
    chk("abort_accepts", drop, 0);
    chk("collide_fs", frame_start, 1);
    chk("collide_old", pix, 0);
    tick();
    chk("collide_new", pix, 3);
    do_reset();
    tick();
    tick();
    chk("next_frame", pix, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_framebuffer.md
Name: plot_framebuffer

Overview:
- Receiving end of the pixel-plot interface (X/Y/colour/plot strobe) that the box and line drawing FSMs drive.
- Accepts single-pixel writes into an on-chip 160x120 x 3-bit frame buffer.
- Continuously scans the buffer out as 640x480 VGA timing, replicating each pixel 4x4.
- Provides a hardware full-screen clear sequencer, so drawing FSMs no longer have to erase with pixel loops.

Parameters:
X_PIXELS, 160, frame buffer width in pixels
Y_PIXELS, 120, frame buffer height in pixels
SCALE_LOG2, 2, log2 of pixel replication factor (4x4)
H_ACTIVE, 640, visible pixel clocks per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch

Ports:
iClock  input  1  single clock; also the pixel clock (25 MHz nominal)
iResetn  input  1  asynchronous, active-low reset
iX  input  8  plot X coordinate
iY  input  7  plot Y coordinate
iColour  input  3  plot colour
iPlot  input  1  plot strobe; one write per high cycle
iClear  input  1  start full-buffer clear to colour 0
oReady  output  1  high when plots are accepted (not clearing)
oDrop  output  1  one-cycle pulse when a plot is rejected
oColour  output  3  scan-out pixel colour (0 outside active area)
oHS  output  1  horizontal sync, active low
oVS  output  1  vertical sync, active low
oBlank_n  output  1  high during active video
oFrameStart  output  1  one-cycle pulse aligned with first active pixel of a frame

Behaviour:

Reset (async, iResetn=0):
- Clear FSM goes to IDLE; h/v counters go to 0; pipeline registers are cleared.
- Output reset values: oReady=1, oDrop=0, oColour=0, oHS=1, oVS=1, oBlank_n=0, oFrameStart=0.
- Frame buffer contents are NOT reset and are undefined after power-up. A reset mid-clear abandons the clear.

Write address:
- addr = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x; no multiplier.

Plot handling, when iPlot=1 in a cycle:
- Accepted if FSM is IDLE, iClear=0, iX<X_PIXELS and iY<Y_PIXELS. Memory is written at the next clock edge.
- Otherwise rejected: no write, and oDrop=1 on the following cycle.
- Consecutive plot cycles are each accepted independently; there is no backpressure beyond oReady.

Clear FSM:
- IDLE -> CLEAR when iClear=1. oReady falls the cycle after iClear is sampled.
- CLEAR writes colour 0 to addresses 0..19199, one per cycle, via an internal 15-bit counter.
- CLEAR -> IDLE after address 19199 is written, i.e. 19200 cycles in CLEAR. oReady returns to 1 on the following cycle.
- iClear while in CLEAR is ignored and does not restart the clear.
- If iClear and iPlot are high in the same IDLE cycle, the clear wins and the plot is dropped (oDrop pulses).

Scan-out timing:
- h counter runs 0..799 and wraps; v counter increments when h wraps, runs 0..524 and wraps.
- Raw active = (h<640)&&(v<480).
- Raw hsync low for h in 656..751.
- Raw vsync low for v in 490..491.
- Read address = (v>>2)*160 + (h>>2), valid when active.
- Frame buffer read is synchronous with 1-cycle latency; the address is registered first, giving 2 cycles total.
- oHS, oVS, oBlank_n and oFrameStart are delayed by 2 cycles so they align with oColour.
- oColour = read data when delayed blank_n=1, else 0.
- oFrameStart = delayed (h==0 && v==0).

Read/write collision:
- A write and a scan read to the same address in the same cycle return the old data to scan-out.
- A plot or clear write never stalls scan-out.

Test Plan:
- Reset, then run 420000 cycles -> oHS period 800 with a 96-cycle low; oVS period 420000 with a 1600-cycle low; oFrameStart once per frame; oBlank_n high for 640 of every 800 cycles on lines 0..479.
- iClear, wait for oReady=1, plot (5,3,colour 6) -> next frame: oColour=6 exactly on lines 12..15, columns 20..23; elsewhere 0.
- Plot (160,0,7) and (0,120,7) -> oDrop pulses once per plot; the scanned frame is unchanged.
- iClear pulse -> oReady low for exactly 19200 cycles. A plot (1,1,5) issued mid-clear -> oDrop pulses and no write. After completion, every active pixel of the next frame is 0.
- iClear and iPlot high in the same IDLE cycle -> clear starts and oDrop pulses. Assert iResetn=0 at cycle 5000 of a clear -> oReady=1 immediately; FSM is IDLE after release and accepts plots.
- Plot (0,0,3) in the same cycle the scan reads address 0 -> that frame shows the old value; the next frame shows 3.
